// File: rtl/mem_lsu.sv
// Single-outstanding load/store initiator for a word-addressed data memory with an
// async read port and a posedge write port. Out-of-range addresses are flagged, not aliased.
module mem_lsu #(
  parameter int unsigned p_WORD_LEN    = 16,
  parameter int unsigned p_ADDR_LEN    = 10,
  parameter int unsigned p_CORE_ALEN   = 16,
  parameter int unsigned p_WAIT_CYCLES = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_we,
  input  logic [p_CORE_ALEN-1:0] i_req_addr,
  input  logic [p_WORD_LEN-1:0]  i_req_wdata,
  output logic                   o_resp_valid,
  input  logic                   i_resp_ready,
  output logic [p_WORD_LEN-1:0]  o_resp_rdata,
  output logic                   o_resp_err,
  output logic [p_ADDR_LEN-1:0]  o_mem_addr,
  output logic                   o_mem_wr_en,
  output logic [p_WORD_LEN-1:0]  o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0]  i_mem_rd_data
);

  localparam int unsigned CntW = (p_WAIT_CYCLES > 0) ? $clog2(p_WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [p_ADDR_LEN-1:0] addr_q, addr_d;
  logic [p_WORD_LEN-1:0] wdata_q, wdata_d;
  logic [p_WORD_LEN-1:0] rdata_q, rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  addr_oor;

  // Any set bit above the memory's address lines means the word does not exist.
  if (p_CORE_ALEN > p_ADDR_LEN) begin : g_oor
    assign addr_oor = |i_req_addr[p_CORE_ALEN-1:p_ADDR_LEN];
  end else begin : g_no_oor
    assign addr_oor = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          addr_d  = i_req_addr[p_ADDR_LEN-1:0];
          wdata_d = i_req_wdata;
          err_d   = addr_oor;
          cnt_d   = CntW'(p_WAIT_CYCLES);
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          // Read data is captured at the edge that closes the access.
          rdata_d    = (!we_q && !err_q) ? i_mem_rd_data : '0;
          resp_err_d = err_q;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (i_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign o_req_ready   = (state_q == StIdle);
  assign o_resp_valid  = (state_q == StResp);
  assign o_resp_rdata  = rdata_q;
  assign o_resp_err    = resp_err_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wr_data = wdata_q;
  // Gated on reset so a reset landing in the final access cycle cancels the write.
  assign o_mem_wr_en   = (state_q == StAccess) && (cnt_q == '0) && we_q && !err_q && i_rst_n;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: three instances (wait 1, 0, 3) share one stimulus bus and one memory;
// a scoreboard queue holds expected responses computed from a reference memory image.
module tb_mem_lsu;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_ready;

  logic        req_valid_a  [3];
  logic        ready_a      [3];
  logic        resp_valid_a [3];
  logic [15:0] rdata_a      [3];
  logic        err_a        [3];
  logic [9:0]  maddr_a      [3];
  logic        wr_en_a      [3];
  logic [15:0] wdata_a      [3];

  logic        req_ready, resp_valid, resp_err, wr_any;
  logic [15:0] resp_rdata, mem_wr_data, rd_data;
  logic [9:0]  mem_addr;

  logic [15:0] mem     [1024];
  logic [15:0] exp_mem [1024];
  exp_t        sb [$];
  int          n_pass  = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign req_valid_a[g] = req_valid && (sel == 2'(g));
    mem_lsu #(
      .p_WORD_LEN   (16),
      .p_ADDR_LEN   (10),
      .p_CORE_ALEN  (16),
      .p_WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid_a[g]),
      .o_req_ready  (ready_a[g]),
      .i_req_we     (req_we),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_resp_valid (resp_valid_a[g]),
      .i_resp_ready (resp_ready),
      .o_resp_rdata (rdata_a[g]),
      .o_resp_err   (err_a[g]),
      .o_mem_addr   (maddr_a[g]),
      .o_mem_wr_en  (wr_en_a[g]),
      .o_mem_wr_data(wdata_a[g]),
      .i_mem_rd_data(rd_data)
    );
  end

  assign req_ready   = ready_a[sel];
  assign resp_valid  = resp_valid_a[sel];
  assign resp_rdata  = rdata_a[sel];
  assign resp_err    = err_a[sel];
  assign mem_addr    = maddr_a[sel];
  assign mem_wr_data = wdata_a[sel];
  assign wr_any      = wr_en_a[0] | wr_en_a[1] | wr_en_a[2];
  assign rd_data     = mem[mem_addr];

  always @(posedge clk) begin
    if (wr_any) mem[mem_addr] <= mem_wr_data;
  end

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 37) ^ 16'hC3A5;
  endfunction

  function automatic int wait_of(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Entered and left at #1 after a rising edge with the selected DUT idle.
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int hold);
    int   k;
    int   wr_seen;
    int   wr_k;
    int   w;
    logic err;
    exp_t e;
    exp_t got;
    w       = wait_of(sel);
    err     = |addr[15:10];
    e.err   = err;
    e.rdata = (we || err) ? 16'h0 : exp_mem[addr[9:0]];
    if (we && !err) exp_mem[addr[9:0]] = wdata;
    sb.push_back(e);

    check("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 0);
    check("mem_addr_latch", mem_addr, addr[9:0]);

    wr_seen = 0;
    wr_k    = -1;
    k       = 0;
    while (!resp_valid && k < 40) begin
      if (wr_any) begin
        wr_seen++;
        wr_k = k;
      end
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, w + 1);
    check("wr_count", wr_seen, (we && !err) ? 1 : 0);
    if (wr_seen == 1) check("wr_cycle", wr_k, w);

    got = sb.pop_front();
    check("resp_rdata", resp_rdata, got.rdata);
    check("resp_err", resp_err, got.err);

    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = addr ^ 16'h0155;
      req_wdata = ~wdata;
      @(posedge clk); #1;
      check("bp_valid", resp_valid, 1);
      check("bp_rdata", resp_rdata, got.rdata);
      check("bp_err", resp_err, got.err);
      check("bp_req_ready", req_ready, 0);
      check("bp_no_write", wr_any, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 0);
    check("req_ready_back", req_ready, 1);
    check("mem_addr_hold", mem_addr, addr[9:0]);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = init_val(i);
      exp_mem[i] = init_val(i);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    sel        = 2'd0;
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 16'h0005;
    req_wdata  = 16'hFFFF;
    resp_ready = 1'b1;

    // Reset with a request pending.
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check("rst_resp_valid", resp_valid, 0);
      check("rst_rdata", resp_rdata, 0);
      check("rst_err", resp_err, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_wr_data", mem_wr_data, 0);
      check("rst_req_ready", req_ready, 1);
    end
    check("rst_no_write", wr_any, 0);
    sel        = 2'd0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    rst_n      = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", req_ready, 1);
    check("post_rst_valid", resp_valid, 0);

    // Store then load back, wait = 1.
    do_req(1'b1, 16'h0005, 16'hBEEF, 0);
    do_req(1'b0, 16'h0005, 16'h0000, 0);

    // Out-of-range accesses.
    do_req(1'b0, 16'h0400, 16'h0000, 0);
    do_req(1'b1, 16'hFFFF, 16'h1234, 0);
    check("mem3ff_kept", mem[10'h3FF], exp_mem[10'h3FF]);
    do_req(1'b0, 16'h03FF, 16'h0000, 0);

    // Response back-pressure with ignored requests.
    do_req(1'b0, 16'h0010, 16'h0000, 5);
    do_req(1'b1, 16'h0020, 16'h5A5A, 5);
    do_req(1'b0, 16'h0020, 16'h0000, 0);

    // Reset during the final access cycle of a store.
    check("r5_ready", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 16'h0007;
    req_wdata  = 16'hAAAA;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("r5_wr_early", wr_any, 0);
    @(posedge clk); #1;
    check("r5_wr_final", wr_any, 1);
    rst_n = 1'b0;
    #1;
    check("r5_wr_gated", wr_any, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("r5_valid", resp_valid, 0);
    check("r5_ready_after", req_ready, 1);
    check("r5_mem_addr", mem_addr, 0);
    check("r5_mem7_kept", mem[7], exp_mem[7]);
    do_req(1'b0, 16'h0007, 16'h0000, 0);

    // Back-to-back traffic at wait 0 and wait 3.
    for (int s = 1; s < 3; s++) begin
      sel = 2'(s);
      #1;
      do_req(1'b0, 16'h0005, 16'h0000, 0);
      do_req(1'b1, 16'(s * 16'h0100), 16'(16'h1357 * s), 0);
      do_req(1'b0, 16'(s * 16'h0100), 16'h0000, 0);
      do_req(1'b0, 16'h0400, 16'h0000, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
